vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter VIDEO_WIDTH, default 3: bits per colour channel.
REQ-002 Parameter TOTAL_COLS, default 800: pixel clocks per line.
REQ-003 Parameter TOTAL_ROWS, default 525: lines per frame.
REQ-004 Parameter ACTIVE_COLS, default 640: visible pixels per line.
REQ-005 Parameter ACTIVE_ROWS, default 480: visible lines per frame.
REQ-006 Parameters FRONT_PORCH_HORZ / BACK_PORCH_HORZ, defaults 18 / 50: horizontal porch widths. Horizontal sync width = TOTAL_COLS-ACTIVE_COLS-FP-BP, which is 92 at the defaults.
REQ-007 Parameters FRONT_PORCH_VERT / BACK_PORCH_VERT, defaults 10 / 33: vertical porch widths. Vertical sync width at the defaults = 2.
REQ-008 One clock; reset is synchronous and active-high.
REQ-009 Ports:
- clock, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high.
- ce, in, 1: pixel enable; advances timing when high.
- col, out, 10: current column.
- row, out, 10: current row.
- active, out, 1: col<ACTIVE_COLS and row<ACTIVE_ROWS.
- frame_start, out, 1: one-ce pulse at position (0,0).
- hsync, out, 1: active-low horizontal sync, aligned with col.
- vsync, out, 1: active-low vertical sync, aligned with row.
- iredv / igrnv / ibluv, in, VIDEO_WIDTH each: pixel for the col/row presented in the same cycle.
- ohsync / ovsync, out, 1: hsync/vsync delayed by 2 ce-cycles.
- oredv / ogrnv / obluv, out, VIDEO_WIDTH each: blanked pixel aligned with ohsync/ovsync.

Function
REQ-010 Horizontal FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Boundaries are col = ACTIVE_COLS, +FP, +SYNC, and wrap at TOTAL_COLS-1.
REQ-011 Vertical FSM: same four states, on row boundaries. It advances only on the cycle col wraps TOTAL_COLS-1 -> 0.
REQ-012 col counts 0..TOTAL_COLS-1 and wraps to 0. row increments at the col wrap and wraps TOTAL_ROWS-1 -> 0 at the end of the last line.
REQ-013 hsync = 0 iff the horizontal FSM is in SYNC, i.e. col in [ACTIVE_COLS+FP, TOTAL_COLS-BP-1]; otherwise 1.
REQ-014 vsync = 0 iff the vertical FSM is in SYNC, i.e. row in [ACTIVE_ROWS+FPV, TOTAL_ROWS-BPV-1]; otherwise 1.
REQ-015 col, row, active, hsync, vsync and frame_start are all registered and describe the same position in the same cycle, with zero skew between them.
REQ-016 When ce=0, all registers hold, including the video pipeline, and frame_start is forced to 0.
REQ-017 Video pipeline: stage 1 registers the inputs together with active/hsync/vsync. Stage 2 outputs them. Output colour is 0 when the delayed active is 0. Latency = 2 ce-cycles.
REQ-018 col and row arithmetic is unsigned 10-bit. All parameters must fit in 10 bits; an elaboration-time check rejects a sync width < 1.
REQ-019 reset asserted mid-frame aborts the frame immediately, with no completion of the current line.

Reset
REQ-020 While reset=1, outputs are: col=0, row=0, active=0, frame_start=0, hsync=1, vsync=1, ohsync=1, ovsync=1, colour outputs 0.
REQ-021 On the first ce=1 cycle after reset release, position (0,0) is presented with active=1 and frame_start=1. A primed flag distinguishes this from a normal wrap.
REQ-022 Reset overrides ce.

Structure
REQ-023 A shared package holds the 640x480 timing constants, the four-state porch enumeration, and the sync-width helper function.
REQ-024 One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical). Each instance provides: a counter, the four-state FSM, a wrap output, and an in_sync output.

Verification
REQ-025 Reset, then ce=1 for 420000 cycles. Required: frame_start exactly every 420000 cycles; active high for 307200 cycles per frame.
REQ-026 Line timing over one line: hsync low for exactly cols 658..749, i.e. 92 cycles. active falls at col 640.
REQ-027 Frame timing: vsync low for rows 490..491. row wraps 524 -> 0 on the cycle col wraps 799 -> 0.
REQ-028 ce toggling 1,0,1,0 gives half-rate advance: col reaches 799 after 1600 cycles, with no duplicate frame_start.
REQ-029 iredv=7 constant: oredv=7 exactly 2 ce-cycles after active=1, and oredv=0 for 2 cycles after active falls. ohsync equals hsync delayed 2.
REQ-030 Reset asserted at col=300, row=200 for 1 cycle: next ce=1 cycle shows col=0, row=0, frame_start=1, and hsync/vsync/ohsync=1 during reset.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480 timing constants, porch state encoding and the sync-width helper
// used by the VGA timing generator and its axis counters.
package vga_timing_gen_pkg;

   localparam int VGA_VIDEO_WIDTH  = 32'd3;
   localparam int VGA_TOTAL_COLS   = 32'd800;
   localparam int VGA_TOTAL_ROWS   = 32'd525;
   localparam int VGA_ACTIVE_COLS  = 32'd640;
   localparam int VGA_ACTIVE_ROWS  = 32'd480;
   localparam int VGA_FP_HORZ      = 32'd18;
   localparam int VGA_BP_HORZ      = 32'd50;
   localparam int VGA_FP_VERT      = 32'd10;
   localparam int VGA_BP_VERT      = 32'd33;

   typedef enum logic [1:0] {
      PORCH_ACTIVE = 2'd0,
      PORCH_FRONT  = 2'd1,
      PORCH_SYNC   = 2'd2,
      PORCH_BACK   = 2'd3
   } porch_e;

   function automatic int sync_width(input int total, input int active, input int fp, input int bp);
      return total - active - fp - bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: pixel enable and colour in,
// raster position, sync flags and blanked colour out.
interface vga_timing_gen_if #(
   parameter int VIDEO_WIDTH = 32'd3
);
   logic                   ce;
   logic [VIDEO_WIDTH-1:0] iredv;
   logic [VIDEO_WIDTH-1:0] igrnv;
   logic [VIDEO_WIDTH-1:0] ibluv;
   logic [9:0]             col;
   logic [9:0]             row;
   logic                   active;
   logic                   frame_start;
   logic                   hsync;
   logic                   vsync;
   logic                   ohsync;
   logic                   ovsync;
   logic [VIDEO_WIDTH-1:0] oredv;
   logic [VIDEO_WIDTH-1:0] ogrnv;
   logic [VIDEO_WIDTH-1:0] obluv;

   modport master (
      output ce, iredv, igrnv, ibluv,
      input  col, row, active, frame_start, hsync, vsync,
      input  ohsync, ovsync, oredv, ogrnv, obluv
   );

   modport slave (
      input  ce, iredv, igrnv, ibluv,
      output col, row, active, frame_start, hsync, vsync,
      output ohsync, ovsync, oredv, ogrnv, obluv
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, and the ACTIVE/FRONT/SYNC/BACK
// porch FSM tracking the position the counter will hold after this clock.
module vga_axis_counter
   import vga_timing_gen_pkg::*;
#(
   parameter int TOTAL    = VGA_TOTAL_COLS,
   parameter int ACTIVE_N = VGA_ACTIVE_COLS,
   parameter int FP       = VGA_FP_HORZ,
   parameter int BP       = VGA_BP_HORZ
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       restart,
   input  logic       advance,
   output logic [9:0] count,
   output logic       wrap,
   output logic       in_sync,
   output logic       active_next
);
   localparam int         SYNC_W      = sync_width(TOTAL, ACTIVE_N, FP, BP);
   localparam logic [9:0] LAST        = 10'(TOTAL - 32'd1);
   localparam logic [9:0] FRONT_START = 10'(ACTIVE_N);
   localparam logic [9:0] SYNC_START  = 10'(ACTIVE_N + FP);
   localparam logic [9:0] BACK_START  = 10'(ACTIVE_N + FP + SYNC_W);

   if (SYNC_W < 32'd1) begin : g_sync_width_check
      $error("vga_axis_counter: sync width must be at least 1");
   end
   if (TOTAL > 32'd1024) begin : g_total_width_check
      $error("vga_axis_counter: TOTAL must fit a 10-bit counter");
   end

   logic [9:0] count_d, count_q;
   porch_e     state_d, state_q;
   logic       in_sync_d, in_sync_q;

   // State register: counter, porch state and registered sync flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= 10'd0;
         state_q   <= PORCH_ACTIVE;
         in_sync_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         state_q   <= state_d;
         in_sync_q <= in_sync_d;
      end
   end

   // Next state: later boundaries take priority so zero-width porches are skipped.
   always_comb begin
      count_d = count_q;
      state_d = state_q;
      if (restart) begin
         count_d = 10'd0;
      end else if (advance) begin
         count_d = (count_q == LAST) ? 10'd0 : count_q + 10'd1;
      end else begin
         count_d = count_q;
      end
      if (restart || advance) begin
         if (count_d == 10'd0) begin
            state_d = PORCH_ACTIVE;
         end else if (count_d == BACK_START) begin
            state_d = PORCH_BACK;
         end else if (count_d == SYNC_START) begin
            state_d = PORCH_SYNC;
         end else if (count_d == FRONT_START) begin
            state_d = PORCH_FRONT;
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Output decode of the upcoming state.
   always_comb begin
      in_sync_d   = 1'b0;
      active_next = 1'b0;
      case (state_d)
         PORCH_SYNC:   in_sync_d   = 1'b1;
         PORCH_ACTIVE: active_next = 1'b1;
         default: begin
            in_sync_d   = 1'b0;
            active_next = 1'b0;
         end
      endcase
   end

   assign count   = count_q;
   assign wrap    = (count_q == LAST);
   assign in_sync = in_sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical raster counters with sync, active and
// frame_start flags, plus a two-stage blanked video pipeline.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int VIDEO_WIDTH      = VGA_VIDEO_WIDTH,
   parameter int TOTAL_COLS       = VGA_TOTAL_COLS,
   parameter int TOTAL_ROWS       = VGA_TOTAL_ROWS,
   parameter int ACTIVE_COLS      = VGA_ACTIVE_COLS,
   parameter int ACTIVE_ROWS      = VGA_ACTIVE_ROWS,
   parameter int FRONT_PORCH_HORZ = VGA_FP_HORZ,
   parameter int BACK_PORCH_HORZ  = VGA_BP_HORZ,
   parameter int FRONT_PORCH_VERT = VGA_FP_VERT,
   parameter int BACK_PORCH_VERT  = VGA_BP_VERT
) (
   input  logic            clock,
   input  logic            reset,
   vga_timing_gen_if.slave bus
);
   localparam logic [VIDEO_WIDTH-1:0] BLACK = {VIDEO_WIDTH{1'b0}};

   logic                   primed_d, primed_q;
   logic                   frame_start_d, frame_start_q;
   logic                   active_d, active_q;
   logic                   h_restart, h_advance, v_advance;
   logic                   h_wrap, v_wrap, h_in_sync, v_in_sync;
   logic                   h_active_next, v_active_next;
   logic [9:0]             col_q, row_q;
   logic                   s1_active_d, s1_active_q, s1_hsync_d, s1_hsync_q, s1_vsync_d, s1_vsync_q;
   logic [VIDEO_WIDTH-1:0] s1_red_d, s1_red_q, s1_grn_d, s1_grn_q, s1_blu_d, s1_blu_q;
   logic                   s2_hsync_d, s2_hsync_q, s2_vsync_d, s2_vsync_q;
   logic [VIDEO_WIDTH-1:0] s2_red_d, s2_red_q, s2_grn_d, s2_grn_q, s2_blu_d, s2_blu_q;

   vga_axis_counter #(
      .TOTAL(TOTAL_COLS), .ACTIVE_N(ACTIVE_COLS), .FP(FRONT_PORCH_HORZ), .BP(BACK_PORCH_HORZ)
   ) u_horz (
      .clock(clock), .reset(reset), .restart(h_restart), .advance(h_advance),
      .count(col_q), .wrap(h_wrap), .in_sync(h_in_sync), .active_next(h_active_next)
   );

   vga_axis_counter #(
      .TOTAL(TOTAL_ROWS), .ACTIVE_N(ACTIVE_ROWS), .FP(FRONT_PORCH_VERT), .BP(BACK_PORCH_VERT)
   ) u_vert (
      .clock(clock), .reset(reset), .restart(h_restart), .advance(v_advance),
      .count(row_q), .wrap(v_wrap), .in_sync(v_in_sync), .active_next(v_active_next)
   );

   // Advance control; the first enabled cycle after reset presents (0,0) instead of stepping.
   always_comb begin
      h_restart     = bus.ce & ~primed_q;
      h_advance     = bus.ce & primed_q;
      v_advance     = h_advance & h_wrap;
      primed_d      = primed_q | bus.ce;
      frame_start_d = 1'b0;
      active_d      = active_q;
      s1_active_d   = s1_active_q;
      s1_hsync_d    = s1_hsync_q;
      s1_vsync_d    = s1_vsync_q;
      s1_red_d      = s1_red_q;
      s1_grn_d      = s1_grn_q;
      s1_blu_d      = s1_blu_q;
      s2_hsync_d    = s2_hsync_q;
      s2_vsync_d    = s2_vsync_q;
      s2_red_d      = s2_red_q;
      s2_grn_d      = s2_grn_q;
      s2_blu_d      = s2_blu_q;
      if (bus.ce) begin
         frame_start_d = ~primed_q | (h_wrap & v_wrap);
         active_d      = h_active_next & v_active_next;
         s1_active_d   = active_q;
         s1_hsync_d    = ~h_in_sync;
         s1_vsync_d    = ~v_in_sync;
         s1_red_d      = bus.iredv;
         s1_grn_d      = bus.igrnv;
         s1_blu_d      = bus.ibluv;
         s2_hsync_d    = s1_hsync_q;
         s2_vsync_d    = s1_vsync_q;
         s2_red_d      = s1_active_q ? s1_red_q : BLACK;
         s2_grn_d      = s1_active_q ? s1_grn_q : BLACK;
         s2_blu_d      = s1_active_q ? s1_blu_q : BLACK;
      end else begin
         frame_start_d = 1'b0;
      end
   end

   // Flag and video pipeline registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         primed_q      <= 1'b0;
         frame_start_q <= 1'b0;
         active_q      <= 1'b0;
         s1_active_q   <= 1'b0;
         s1_hsync_q    <= 1'b1;
         s1_vsync_q    <= 1'b1;
         s1_red_q      <= BLACK;
         s1_grn_q      <= BLACK;
         s1_blu_q      <= BLACK;
         s2_hsync_q    <= 1'b1;
         s2_vsync_q    <= 1'b1;
         s2_red_q      <= BLACK;
         s2_grn_q      <= BLACK;
         s2_blu_q      <= BLACK;
      end else begin
         primed_q      <= primed_d;
         frame_start_q <= frame_start_d;
         active_q      <= active_d;
         s1_active_q   <= s1_active_d;
         s1_hsync_q    <= s1_hsync_d;
         s1_vsync_q    <= s1_vsync_d;
         s1_red_q      <= s1_red_d;
         s1_grn_q      <= s1_grn_d;
         s1_blu_q      <= s1_blu_d;
         s2_hsync_q    <= s2_hsync_d;
         s2_vsync_q    <= s2_vsync_d;
         s2_red_q      <= s2_red_d;
         s2_grn_q      <= s2_grn_d;
         s2_blu_q      <= s2_blu_d;
      end
   end

   assign bus.col         = col_q;
   assign bus.row         = row_q;
   assign bus.active      = active_q;
   assign bus.frame_start = frame_start_q;
   assign bus.hsync       = ~h_in_sync;
   assign bus.vsync       = ~v_in_sync;
   assign bus.ohsync      = s2_hsync_q;
   assign bus.ovsync      = s2_vsync_q;
   assign bus.oredv       = s2_red_q;
   assign bus.ogrnv       = s2_grn_q;
   assign bus.obluv       = s2_blu_q;

endmodule
